// File: rtl/execute_stage_if.sv
// Signal bundle around the execute stage: decode handshake, shared ALU hookup,
// memory-side output buffer and condition codes.
interface execute_stage_if #(
    parameter int unsigned DataW = 32
);
    logic             d_valid;
    logic             d_ready;
    logic [3:0]       d_icode;
    logic [3:0]       d_ifun;
    logic [DataW-1:0] d_valA;
    logic [DataW-1:0] d_valB;
    logic [DataW-1:0] d_valC;
    logic [3:0]       d_dstE;
    logic [3:0]       d_dstM;

    logic [DataW-1:0] alu_a;
    logic [DataW-1:0] alu_b;
    logic [3:0]       alu_fun;
    logic [DataW-1:0] alu_valE;

    logic             e_squash;

    logic             m_valid;
    logic             m_ready;
    logic [3:0]       m_icode;
    logic [1:0]       m_stat;
    logic             m_cnd;
    logic [DataW-1:0] m_valE;
    logic [DataW-1:0] m_valA;
    logic [3:0]       m_dstE;
    logic [3:0]       m_dstM;

    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;

    // Environment side: decode, ALU and memory stage.
    modport master (
        output d_valid, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
        output alu_valE, e_squash, m_ready,
        input  d_ready, alu_a, alu_b, alu_fun,
        input  m_valid, m_icode, m_stat, m_cnd, m_valE, m_valA, m_dstE, m_dstM,
        input  cc_zf, cc_sf, cc_of
    );

    // Execute stage side.
    modport slave (
        input  d_valid, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
        input  alu_valE, e_squash, m_ready,
        output d_ready, alu_a, alu_b, alu_fun,
        output m_valid, m_icode, m_stat, m_cnd, m_valE, m_valA, m_dstE, m_dstM,
        output cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: selects operands for the shared ALU, owns the condition codes,
// evaluates jXX/cmovXX conditions and registers results into a 1-entry buffer.
module execute_stage #(
    parameter int unsigned DataW     = 32,
    parameter logic [3:0]  Rnone     = 4'hF,
    parameter int unsigned StackStep = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    execute_stage_if.slave bus
);
    localparam int unsigned Msb = DataW - 1;

    localparam logic [3:0] IHalt  = 4'h0;
    localparam logic [3:0] ICmov  = 4'h2;
    localparam logic [3:0] IIrmov = 4'h3;
    localparam logic [3:0] IRmmov = 4'h4;
    localparam logic [3:0] IMrmov = 4'h5;
    localparam logic [3:0] IOp    = 4'h6;
    localparam logic [3:0] IJxx   = 4'h7;
    localparam logic [3:0] ICall  = 4'h8;
    localparam logic [3:0] IRet   = 4'h9;
    localparam logic [3:0] IPush  = 4'hA;
    localparam logic [3:0] IPop   = 4'hB;

    localparam logic [3:0] AluAdd = 4'h0;
    localparam logic [3:0] AluSub = 4'h1;

    localparam logic [1:0] StatAok = 2'd0;
    localparam logic [1:0] StatHlt = 2'd1;
    localparam logic [1:0] StatIns = 2'd2;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [DataW-1:0] alu_a, alu_b;
    logic [3:0]       alu_fun;
    logic [1:0]       stat;
    logic             cnd;
    logic             new_zf, new_sf, new_of;
    logic             ready, accept;

    logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic             m_valid_q, m_valid_d;
    logic [3:0]       m_icode_q, m_icode_d;
    logic [1:0]       m_stat_q, m_stat_d;
    logic             m_cnd_q, m_cnd_d;
    logic [DataW-1:0] m_val_e_q, m_val_e_d;
    logic [DataW-1:0] m_val_a_q, m_val_a_d;
    logic [3:0]       m_dst_e_q, m_dst_e_d;
    logic [3:0]       m_dst_m_q, m_dst_m_d;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fun = AluAdd;
        case (bus.d_icode)
            ICmov:  alu_a = bus.d_valA;
            IIrmov: alu_a = bus.d_valC;
            IRmmov, IMrmov: begin
                alu_a = bus.d_valC;
                alu_b = bus.d_valB;
            end
            IOp: begin
                alu_a   = bus.d_valB;
                alu_b   = bus.d_valA;
                alu_fun = bus.d_ifun;
            end
            ICall, IPush: begin
                alu_a   = bus.d_valB;
                alu_b   = DataW'(StackStep);
                alu_fun = AluSub;
            end
            IRet, IPop: begin
                alu_a = bus.d_valB;
                alu_b = DataW'(StackStep);
            end
            default: ;
        endcase
    end

    always_comb begin
        stat = StatAok;
        if (bus.d_icode > 4'hB || (bus.d_icode == IOp && bus.d_ifun > 4'd3) ||
            ((bus.d_icode == ICmov || bus.d_icode == IJxx) && bus.d_ifun > 4'd6)) begin
            stat = StatIns;
        end else if (bus.d_icode == IHalt) begin
            stat = StatHlt;
        end
    end

    // Conditions read the registered flags, so an OP accepted last cycle is already visible.
    always_comb begin
        cnd = 1'b1;
        if (bus.d_icode == ICmov || bus.d_icode == IJxx) begin
            case (bus.d_ifun)
                4'd0:    cnd = 1'b1;
                4'd1:    cnd = (sf_q ^ of_q) | zf_q;
                4'd2:    cnd = sf_q ^ of_q;
                4'd3:    cnd = zf_q;
                4'd4:    cnd = ~zf_q;
                4'd5:    cnd = ~(sf_q ^ of_q);
                4'd6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
                default: cnd = 1'b0;
            endcase
        end
    end

    always_comb begin
        new_zf = (bus.alu_valE == '0);
        new_sf = bus.alu_valE[Msb];
        case (alu_fun)
            AluAdd:  new_of = (alu_a[Msb] == alu_b[Msb]) && (bus.alu_valE[Msb] != alu_a[Msb]);
            AluSub:  new_of = (alu_a[Msb] != alu_b[Msb]) && (bus.alu_valE[Msb] != alu_a[Msb]);
            default: new_of = 1'b0;
        endcase
    end

    always_comb begin
        ready  = (state_q == StRun) && (!m_valid_q || bus.m_ready) && !bus.e_squash;
        accept = bus.d_valid && ready;

        state_d = state_q;
        if (accept && stat != StatAok) begin
            state_d = StHalt;
        end

        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (accept && bus.d_icode == IOp && stat == StatAok) begin
            zf_d = new_zf;
            sf_d = new_sf;
            of_d = new_of;
        end

        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_stat_d  = m_stat_q;
        m_cnd_d   = m_cnd_q;
        m_val_e_d = m_val_e_q;
        m_val_a_d = m_val_a_q;
        m_dst_e_d = m_dst_e_q;
        m_dst_m_d = m_dst_m_q;
        if (bus.e_squash) begin
            m_valid_d = 1'b0;
        end else if (accept) begin
            m_valid_d = 1'b1;
            m_icode_d = bus.d_icode;
            m_stat_d  = stat;
            m_cnd_d   = cnd;
            m_val_e_d = bus.alu_valE;
            m_val_a_d = bus.d_valA;
            m_dst_e_d = bus.d_dstE;
            m_dst_m_d = bus.d_dstM;
            if (stat == StatIns) begin
                m_dst_e_d = Rnone;
                m_dst_m_d = Rnone;
            end else if (bus.d_icode == ICmov && !cnd) begin
                m_dst_e_d = Rnone;
            end
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            zf_q      <= 1'b1;
            sf_q      <= 1'b0;
            of_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_icode_q <= 4'h0;
            m_stat_q  <= StatAok;
            m_cnd_q   <= 1'b0;
            m_val_e_q <= '0;
            m_val_a_q <= '0;
            m_dst_e_q <= Rnone;
            m_dst_m_q <= Rnone;
        end else begin
            state_q   <= state_d;
            zf_q      <= zf_d;
            sf_q      <= sf_d;
            of_q      <= of_d;
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_stat_q  <= m_stat_d;
            m_cnd_q   <= m_cnd_d;
            m_val_e_q <= m_val_e_d;
            m_val_a_q <= m_val_a_d;
            m_dst_e_q <= m_dst_e_d;
            m_dst_m_q <= m_dst_m_d;
        end
    end

    assign bus.d_ready = ready;
    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;
    assign bus.alu_fun = alu_fun;
    assign bus.m_valid = m_valid_q;
    assign bus.m_icode = m_icode_q;
    assign bus.m_stat  = m_stat_q;
    assign bus.m_cnd   = m_cnd_q;
    assign bus.m_valE  = m_val_e_q;
    assign bus.m_valA  = m_val_a_q;
    assign bus.m_dstE  = m_dst_e_q;
    assign bus.m_dstM  = m_dst_m_q;
    assign bus.cc_zf   = zf_q;
    assign bus.cc_sf   = sf_q;
    assign bus.cc_of   = of_q;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: vector table through a scoreboard, plus hand-written
// stall, halt, illegal-instruction, squash and asynchronous-reset sequences.
module tb_execute_stage;
    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [31:0] val_a;
        logic [31:0] val_b;
        logic [31:0] val_c;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [31:0] exp_val_e;
        logic [1:0]  exp_stat;
        logic        exp_cnd;
        logic [3:0]  exp_dst_e;
        logic [3:0]  exp_dst_m;
        logic [2:0]  exp_cc;
    } vec_t;

    localparam logic [127:0] RstExp =
        128'({1'b0, 4'h0, 2'd0, 1'b0, 32'd0, 32'd0, 4'hF, 4'hF, 3'b100});

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   w;
    vec_t vecs[$];
    vec_t sb[$];
    vec_t x, mon_e;

    always #5 clk = ~clk;

    execute_stage_if #(.DataW(32)) bus ();

    execute_stage #(
        .DataW    (32),
        .Rnone    (4'hF),
        .StackStep(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference ALU shared with the stage.
    always_comb begin
        case (bus.alu_fun)
            4'd0:    bus.alu_valE = bus.alu_a + bus.alu_b;
            4'd1:    bus.alu_valE = bus.alu_a - bus.alu_b;
            4'd2:    bus.alu_valE = {31'd0, (bus.alu_a != 0) && (bus.alu_b != 0)};
            4'd3:    bus.alu_valE = {31'd0, (bus.alu_a != 0) ^ (bus.alu_b != 0)};
            default: bus.alu_valE = 32'd0;
        endcase
    end

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] vc, input logic [3:0] de,
                                input logic [3:0] dm, input logic [31:0] ev,
                                input logic ec, input logic [3:0] ede, input logic [2:0] ecc);
        vec_t v;
        v.icode = ic;       v.ifun = fn;
        v.val_a = va;       v.val_b = vb;      v.val_c = vc;
        v.dst_e = de;       v.dst_m = dm;
        v.exp_val_e = ev;   v.exp_stat = 2'd0; v.exp_cnd = ec;
        v.exp_dst_e = ede;  v.exp_dst_m = dm;  v.exp_cc = ecc;
        return v;
    endfunction

    function automatic logic [127:0] obs();
        return 128'({bus.m_valid, bus.m_icode, bus.m_stat, bus.m_cnd, bus.m_valE, bus.m_valA,
                     bus.m_dstE, bus.m_dstM, bus.cc_zf, bus.cc_sf, bus.cc_of});
    endfunction

    function automatic logic [127:0] expv(input vec_t v);
        return 128'({1'b1, v.icode, v.exp_stat, v.exp_cnd, v.exp_val_e, v.val_a,
                     v.exp_dst_e, v.exp_dst_m, v.exp_cc});
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic issue(input vec_t v, output int waits);
        waits = 0;
        bus.d_icode = v.icode;
        bus.d_ifun  = v.ifun;
        bus.d_valA  = v.val_a;
        bus.d_valB  = v.val_b;
        bus.d_valC  = v.val_c;
        bus.d_dstE  = v.dst_e;
        bus.d_dstM  = v.dst_m;
        bus.d_valid = 1'b1;
        @(negedge clk);
        while (!bus.d_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (bus.d_ready) begin
            sb.push_back(v);
        end else begin
            n_checks++;
            $display("FAIL issue_timeout: d_ready=0 after %0d cycles, expected 1", waits);
        end
        @(posedge clk);
        #1;
        bus.d_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every transfer to the memory stage is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready && !bus.e_squash) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got icode %h with empty scoreboard, expected none",
                         bus.m_icode);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("out icode=%h ifun=%h", mon_e.icode, mon_e.ifun), obs(),
                      expv(mon_e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.d_valid  = 1'b0;
        bus.d_icode  = 4'h0;
        bus.d_ifun   = 4'h0;
        bus.d_valA   = 32'd0;
        bus.d_valB   = 32'd0;
        bus.d_valC   = 32'd0;
        bus.d_dstE   = 4'hF;
        bus.d_dstM   = 4'hF;
        bus.e_squash = 1'b0;
        bus.m_ready  = 1'b1;

        // icode ifun valA valB valC dstE dstM | valE cnd dstE {zf,sf,of}
        vecs.push_back(mk(4'h6, 4'h0, 32'h1, 32'h7FFFFFFF, 32'h0, 4'h2, 4'hF, 32'h80000000, 1, 4'h2, 3'b011));
        vecs.push_back(mk(4'h7, 4'h2, 32'h100, 32'h0, 32'h200, 4'hF, 4'hF, 32'h0, 0, 4'hF, 3'b011));
        vecs.push_back(mk(4'h6, 4'h1, 32'h5, 32'h5, 32'h0, 4'h3, 4'hF, 32'h0, 1, 4'h3, 3'b100));
        vecs.push_back(mk(4'h7, 4'h3, 32'h0, 32'h0, 32'h40, 4'hF, 4'hF, 32'h0, 1, 4'hF, 3'b100));
        vecs.push_back(mk(4'h2, 4'h2, 32'h55, 32'h0, 32'h0, 4'h3, 4'hF, 32'h55, 0, 4'hF, 3'b100));
        vecs.push_back(mk(4'h3, 4'h0, 32'h0, 32'h0, 32'h10, 4'h4, 4'hF, 32'h10, 1, 4'h4, 3'b100));
        vecs.push_back(mk(4'h4, 4'h0, 32'h9, 32'h1000, 32'h8, 4'hF, 4'hF, 32'h1008, 1, 4'hF, 3'b100));
        vecs.push_back(mk(4'h5, 4'h0, 32'h0, 32'h20, 32'hFFFFFFFC, 4'hF, 4'h5, 32'h1C, 1, 4'hF, 3'b100));
        vecs.push_back(mk(4'h8, 4'h0, 32'h0, 32'h100, 32'h300, 4'h4, 4'hF, 32'hFC, 1, 4'h4, 3'b100));
        vecs.push_back(mk(4'hA, 4'h0, 32'h7, 32'h80, 32'h0, 4'h4, 4'hF, 32'h7C, 1, 4'h4, 3'b100));
        vecs.push_back(mk(4'h9, 4'h0, 32'h7C, 32'h7C, 32'h0, 4'h4, 4'hF, 32'h80, 1, 4'h4, 3'b100));
        vecs.push_back(mk(4'hB, 4'h0, 32'h80, 32'h80, 32'h0, 4'h4, 4'h6, 32'h84, 1, 4'h4, 3'b100));
        vecs.push_back(mk(4'h6, 4'h1, 32'h1, 32'h80000000, 32'h0, 4'h1, 4'hF, 32'h7FFFFFFF, 1, 4'h1, 3'b001));
        vecs.push_back(mk(4'h2, 4'h5, 32'h11, 32'h0, 32'h0, 4'h6, 4'hF, 32'h11, 0, 4'hF, 3'b001));
        vecs.push_back(mk(4'h2, 4'h2, 32'h22, 32'h0, 32'h0, 4'h7, 4'hF, 32'h22, 1, 4'h7, 3'b001));
        vecs.push_back(mk(4'h7, 4'h1, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0, 1, 4'hF, 3'b001));
        vecs.push_back(mk(4'h7, 4'h6, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0, 0, 4'hF, 3'b001));
        vecs.push_back(mk(4'h7, 4'h4, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0, 1, 4'hF, 3'b001));
        vecs.push_back(mk(4'h6, 4'h0, 32'h80000000, 32'h80000000, 32'h0, 4'h2, 4'hF, 32'h0, 1, 4'h2, 3'b101));
        vecs.push_back(mk(4'h2, 4'h3, 32'h33, 32'h0, 32'h0, 4'h1, 4'hF, 32'h33, 1, 4'h1, 3'b101));
        vecs.push_back(mk(4'h6, 4'h3, 32'h0, 32'h5, 32'h0, 4'h2, 4'hF, 32'h1, 1, 4'h2, 3'b000));
        vecs.push_back(mk(4'h6, 4'h2, 32'h3, 32'h0, 32'h0, 4'h2, 4'hF, 32'h0, 1, 4'h2, 3'b100));
        vecs.push_back(mk(4'h1, 4'h0, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0, 1, 4'hF, 3'b100));

        #12;
        check("reset_state", obs(), RstExp);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(vecs[0], w);
        check("op_add_latency", obs(), expv(vecs[0]));
        for (int i = 1; i < vecs.size(); i++) issue(vecs[i], w);
        drain("table_drain");

        // Stall: buffer held for several cycles, then back-to-back transfers.
        bus.m_ready = 1'b0;
        x = mk(4'h3, 4'h0, 32'h0, 32'h0, 32'hA1, 4'h2, 4'hF, 32'hA1, 1, 4'h2, 3'b100);
        issue(x, w);
        bus.d_icode = 4'h3;
        bus.d_valC  = 32'hA2;
        bus.d_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_ready", 128'(bus.d_ready), 128'(0));
            check("stall_hold", obs(), expv(x));
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        issue(mk(4'h3, 4'h0, 32'h0, 32'h0, 32'hA2, 4'h2, 4'hF, 32'hA2, 1, 4'h2, 3'b100), w);
        check("release_wait_y", 128'(w), 128'(0));
        issue(mk(4'h3, 4'h0, 32'h0, 32'h0, 32'hA3, 4'h2, 4'hF, 32'hA3, 1, 4'h2, 3'b100), w);
        check("release_wait_z", 128'(w), 128'(0));
        drain("stall_drain");

        // Halt: drains, then refuses everything until reset.
        x = mk(4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0, 1, 4'hF, 3'b100);
        x.exp_stat = 2'd1;
        issue(x, w);
        bus.d_icode = 4'h1;
        bus.d_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("halt_ready", 128'(bus.d_ready), 128'(0));
        end
        bus.d_valid = 1'b0;
        drain("halt_drain");
        pulse_reset();
        @(negedge clk);
        check("ready_after_reset", 128'(bus.d_ready), 128'(1));
        @(posedge clk);
        #1;

        // Illegal instruction: kills destinations, leaves flags alone, halts.
        issue(mk(4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF, 32'h2, 1, 4'h2, 3'b000), w);
        x = mk(4'hC, 4'h0, 32'h12, 32'h34, 32'h56, 4'h2, 4'h3, 32'h0, 1, 4'hF, 3'b000);
        x.exp_stat  = 2'd2;
        x.exp_dst_m = 4'hF;
        issue(x, w);
        bus.d_icode = 4'h1;
        bus.d_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ins_ready", 128'(bus.d_ready), 128'(0));
        end
        bus.d_valid = 1'b0;
        drain("ins_drain");
        pulse_reset();

        // Squash beats m_ready and blocks the pending accept.
        issue(mk(4'h3, 4'h0, 32'h0, 32'h0, 32'h77, 4'h1, 4'hF, 32'h77, 1, 4'h1, 3'b100), w);
        bus.e_squash = 1'b1;
        bus.d_icode  = 4'h1;
        bus.d_valid  = 1'b1;
        @(negedge clk);
        check("squash_no_accept", 128'(bus.d_ready), 128'(0));
        x = sb.pop_front();
        @(posedge clk);
        #1;
        bus.e_squash = 1'b0;
        bus.d_valid  = 1'b0;
        check("squash_valid_cc", 128'({bus.m_valid, bus.cc_zf, bus.cc_sf, bus.cc_of}),
              128'({1'b0, 3'b100}));

        // Asynchronous reset in the middle of a stall.
        bus.m_ready = 1'b0;
        issue(mk(4'h6, 4'h1, 32'h2, 32'h9, 32'h0, 4'h5, 4'hF, 32'h7, 1, 4'h5, 3'b000), w);
        bus.d_icode = 4'h3;
        bus.d_valC  = 32'h99;
        bus.d_valid = 1'b1;
        @(negedge clk);
        check("stall2_ready", 128'(bus.d_ready), 128'(0));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", obs(), RstExp);
        bus.d_valid = 1'b0;
        sb.delete();
        #1 rst_n = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 128'(bus.m_valid), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
